// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit and the pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_LU_STALL = 2'd1,
    PC_FLUSH    = 2'd2,
    PC_ILLEGAL  = 2'd3
  } pc_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter used for the pipeline performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/bubble arbitration, load-use interlock, flush sequencing.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES       = 5,
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic [REG_AW-1:0] id_raddr1,
  input  logic [REG_AW-1:0] id_raddr2,
  input  logic              ex_is_load,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [STAGES:0]   stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int LU_CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int FL_CW = $clog2(FLUSH_CYCLES + 1);

  pc_state_e         state_q, state_d;
  logic [LU_CW-1:0]  lu_cnt_q, lu_cnt_d;
  logic [FL_CW-1:0]  fl_cnt_q, fl_cnt_d;
  logic [31:0]       new_pc_q, new_pc_d;

  logic              lu;
  logic [STAGES-1:0] req;
  int                k;
  logic [STAGES:0]   stall_c;
  logic [STAGES-1:0] bubble_c;
  logic              flush_c;

  // Index of the highest requesting stage, -1 when nobody asks.
  function automatic int top_req(input logic [STAGES-1:0] r);
    int idx;
    idx = -1;
    for (int i = 0; i < STAGES; i++) begin
      if (r[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

  assign lu = ex_is_load & ex_wreg & (ex_wd != '0) &
              ((id_re1 & (id_raddr1 == ex_wd)) | (id_re2 & (id_raddr2 == ex_wd)));

  // Merge the interlock into the per-stage requests as a request from ID.
  always_comb begin
    req = stallreq;
    if (lu || (state_q == PC_LU_STALL)) begin
      req[STG_ID] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PC_RUN;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
      new_pc_q <= ZERO_WORD;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next state: a redirect pre-empts everything, including an ongoing flush.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    new_pc_d = new_pc_q;
    if (flush_req) begin
      state_d  = PC_FLUSH;
      fl_cnt_d = FL_CW'(FLUSH_CYCLES);
      new_pc_d = flush_pc;
    end else begin
      case (state_q)
        PC_RUN: begin
          if (lu && (LOAD_LAT > 1)) begin
            state_d  = PC_LU_STALL;
            lu_cnt_d = LU_CW'(LOAD_LAT - 1);
          end
        end
        PC_LU_STALL: begin
          lu_cnt_d = lu_cnt_q - LU_CW'(1);
          if (lu_cnt_q == LU_CW'(1)) begin
            state_d = PC_RUN;
          end
        end
        PC_FLUSH: begin
          fl_cnt_d = fl_cnt_q - FL_CW'(1);
          if (fl_cnt_q == FL_CW'(1)) begin
            state_d = PC_RUN;
          end
        end
        default: begin
          state_d = PC_RUN;
        end
      endcase
    end
  end

  // Outputs: stall everything up to the top requester, bubble the register behind it.
  always_comb begin
    stall_c  = '0;
    bubble_c = '0;
    flush_c  = 1'b0;
    k        = top_req(req);
    if (rst) begin
      case (state_q)
        PC_RUN, PC_LU_STALL: begin
          if (k >= 0) begin
            for (int i = 0; i <= STAGES; i++) begin
              stall_c[i] = (i <= k);
            end
            for (int i = 0; i < STAGES - 1; i++) begin
              bubble_c[i] = (i == k);
            end
          end
        end
        PC_FLUSH: begin
          flush_c  = 1'b1;
          bubble_c = '1;
        end
        default: begin
        end
      endcase
    end
  end

  assign stall  = stall_c;
  assign bubble = bubble_c;
  assign flush  = flush_c;
  assign new_pc = new_pc_q;
  assign state  = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_c[0]),
    .clr (1'b0),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_req),
    .clr (1'b0),
    .cnt (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench: dut_a (LOAD_LAT=1, FLUSH_CYCLES=2), dut_b (LOAD_LAT=3, CNT_W=4).
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  logic [4:0]  a_stallreq, b_stallreq;
  logic        a_id_re1, a_id_re2, b_id_re1, b_id_re2;
  logic [4:0]  a_id_raddr1, a_id_raddr2, b_id_raddr1, b_id_raddr2;
  logic        a_ex_is_load, a_ex_wreg, b_ex_is_load, b_ex_wreg;
  logic [4:0]  a_ex_wd, b_ex_wd;
  logic        a_flush_req, b_flush_req;
  logic [31:0] a_flush_pc, b_flush_pc;

  logic [5:0]  a_stall, b_stall;
  logic [4:0]  a_bubble, b_bubble;
  logic        a_flush, b_flush;
  logic [31:0] a_new_pc, b_new_pc;
  logic [1:0]  a_state, b_state;
  logic [31:0] a_stall_cycles, a_flush_count;
  logic [3:0]  b_stall_cycles, b_flush_count;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STAGES(5), .REG_AW(5), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .stallreq(a_stallreq),
    .id_re1(a_id_re1), .id_re2(a_id_re2), .id_raddr1(a_id_raddr1), .id_raddr2(a_id_raddr2),
    .ex_is_load(a_ex_is_load), .ex_wreg(a_ex_wreg), .ex_wd(a_ex_wd),
    .flush_req(a_flush_req), .flush_pc(a_flush_pc),
    .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .new_pc(a_new_pc),
    .state(a_state), .stall_cycles(a_stall_cycles), .flush_count(a_flush_count)
  );

  pipe_ctrl #(.STAGES(5), .REG_AW(5), .LOAD_LAT(3), .FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .stallreq(b_stallreq),
    .id_re1(b_id_re1), .id_re2(b_id_re2), .id_raddr1(b_id_raddr1), .id_raddr2(b_id_raddr2),
    .ex_is_load(b_ex_is_load), .ex_wreg(b_ex_wreg), .ex_wd(b_ex_wd),
    .flush_req(b_flush_req), .flush_pc(b_flush_pc),
    .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .new_pc(b_new_pc),
    .state(b_state), .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    a_stallreq = '0; a_id_re1 = 0; a_id_re2 = 0; a_id_raddr1 = '0; a_id_raddr2 = '0;
    a_ex_is_load = 0; a_ex_wreg = 0; a_ex_wd = '0; a_flush_req = 0; a_flush_pc = '0;
  endtask

  task automatic clear_b();
    b_stallreq = '0; b_id_re1 = 0; b_id_re2 = 0; b_id_raddr1 = '0; b_id_raddr2 = '0;
    b_ex_is_load = 0; b_ex_wreg = 0; b_ex_wd = '0; b_flush_req = 0; b_flush_pc = '0;
  endtask

  initial begin
    rst = 1'b0;
    clear_a();
    clear_b();
    #2;
    // Reset values, and outputs held low while in reset even with a request.
    chk("rst_state", a_state, 0);
    chk("rst_new_pc", a_new_pc, 0);
    chk("rst_stall_cycles", a_stall_cycles, 0);
    chk("rst_flush_count", a_flush_count, 0);
    a_stallreq = 5'b00100;
    #1;
    chk("rst_stall_forced", a_stall, 0);
    chk("rst_bubble_forced", a_bubble, 0);
    chk("rst_flush_forced", a_flush, 0);
    a_stallreq = '0;
    tick();
    rst = 1'b1;
    tick();

    // Load-use on operand 2, LOAD_LAT=1.
    a_ex_is_load = 1; a_ex_wreg = 1; a_ex_wd = 5; a_id_re2 = 1; a_id_raddr2 = 5;
    #1;
    chk("lu_re2_stall", a_stall, 6'b000011);
    chk("lu_re2_bubble", a_bubble, 5'b00010);
    tick();
    chk("lu_stall_cycles", a_stall_cycles, 1);
    chk("lu_lat1_state", a_state, 0);
    a_ex_wd = 0; a_id_raddr2 = 0;
    #1;
    chk("lu_r0_stall", a_stall, 0);
    chk("lu_r0_bubble", a_bubble, 0);
    clear_a();

    // Load-use on operand 1, then same address with the read disabled.
    a_ex_is_load = 1; a_ex_wreg = 1; a_ex_wd = 7; a_id_re1 = 1; a_id_raddr1 = 7;
    #1;
    chk("lu_re1_stall", a_stall, 6'b000011);
    a_id_re1 = 0;
    #1;
    chk("lu_re1_off_stall", a_stall, 0);

    // Priority: a higher stage request beats the interlock.
    a_id_re1 = 1;
    a_stallreq = 5'b01010;
    #1;
    chk("prio_stall", a_stall, 6'b001111);
    chk("prio_bubble", a_bubble, 5'b01000);
    clear_a();
    a_stallreq = 5'b10000;
    #1;
    chk("top_stage_stall", a_stall, 6'b011111);
    chk("top_stage_bubble", a_bubble, 5'b00000);
    clear_a();

    // Flush with FLUSH_CYCLES=2.
    a_flush_req = 1; a_flush_pc = 32'h40;
    #1;
    chk("flush_req_cycle_flush", a_flush, 0);
    tick();
    a_flush_req = 0;
    chk("flush_c1_flush", a_flush, 1);
    chk("flush_c1_new_pc", a_new_pc, 32'h40);
    chk("flush_c1_bubble", a_bubble, 5'b11111);
    chk("flush_c1_state", a_state, 2);
    chk("flush_count_1", a_flush_count, 1);
    a_stallreq = 5'b00011;
    a_ex_is_load = 1; a_ex_wreg = 1; a_ex_wd = 5; a_id_re2 = 1; a_id_raddr2 = 5;
    #1;
    chk("flush_ignores_req", a_stall, 0);
    clear_a();
    tick();
    chk("flush_c2_flush", a_flush, 1);
    tick();
    chk("flush_done_flush", a_flush, 0);
    chk("flush_done_state", a_state, 0);
    chk("flush_done_stall_cycles", a_stall_cycles, 1);

    // Re-trigger in the first flush cycle.
    a_flush_req = 1; a_flush_pc = 32'h40;
    tick();
    a_flush_pc = 32'h80;
    #1;
    chk("retrig_c1_new_pc", a_new_pc, 32'h40);
    tick();
    a_flush_req = 0;
    chk("retrig_new_pc", a_new_pc, 32'h80);
    chk("retrig_flush_a", a_flush, 1);
    chk("retrig_flush_count", a_flush_count, 3);
    tick();
    chk("retrig_flush_b", a_flush, 1);
    tick();
    chk("retrig_end_flush", a_flush, 0);

    // Build counters to 7 and park in FLUSH, then reset between edges.
    a_stallreq = 5'b00001;
    repeat (6) tick();
    a_stallreq = '0;
    a_flush_req = 1; a_flush_pc = 32'h1234;
    repeat (4) tick();
    a_flush_req = 0;
    chk("pre_rst_state", a_state, 2);
    chk("pre_rst_stall_cycles", a_stall_cycles, 7);
    chk("pre_rst_flush_count", a_flush_count, 7);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_state", a_state, 0);
    chk("midrst_flush", a_flush, 0);
    chk("midrst_stall", a_stall, 0);
    chk("midrst_stall_cycles", a_stall_cycles, 0);
    chk("midrst_flush_count", a_flush_count, 0);
    chk("midrst_new_pc", a_new_pc, 0);
    tick();
    rst = 1'b1;
    tick();

    // LOAD_LAT=3: one lu pulse holds IF/ID for three cycles.
    b_ex_is_load = 1; b_ex_wreg = 1; b_ex_wd = 3; b_id_re1 = 1; b_id_raddr1 = 3;
    #1;
    chk("lat3_c0_stall", b_stall, 6'b000011);
    tick();
    clear_b();
    #1;
    chk("lat3_c1_state", b_state, 1);
    chk("lat3_c1_stall", b_stall, 6'b000011);
    b_stallreq = 5'b00100;
    #1;
    chk("lat3_higher_stall", b_stall, 6'b000111);
    chk("lat3_higher_bubble", b_bubble, 5'b00100);
    b_stallreq = '0;
    tick();
    chk("lat3_c2_stall", b_stall, 6'b000011);
    tick();
    chk("lat3_end_stall", b_stall, 0);
    chk("lat3_end_state", b_state, 0);
    chk("lat3_stall_cycles", b_stall_cycles, 3);

    // Saturation of a 4-bit stall counter.
    b_stallreq = 5'b00001;
    #1;
    chk("if_req_stall", b_stall, 6'b000001);
    chk("if_req_bubble", b_bubble, 5'b00001);
    repeat (12) tick();
    chk("sat_reach_15", b_stall_cycles, 15);
    repeat (8) tick();
    chk("sat_hold_15", b_stall_cycles, 15);
    b_stallreq = '0;

    // FLUSH_CYCLES=1: flush lasts exactly one cycle.
    b_flush_req = 1; b_flush_pc = 32'h100;
    tick();
    b_flush_req = 0;
    chk("b_flush_c1", b_flush, 1);
    chk("b_flush_new_pc", b_new_pc, 32'h100);
    chk("b_flush_count", b_flush_count, 1);
    tick();
    chk("b_flush_end", b_flush, 0);
    chk("b_flush_end_state", b_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
